// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Debug-side reader for the register file. A start pulse walks every
//   register through the file's combinational read port and streams each
//   one to the UART transmitter as LEN/NB_BYTE bytes, MSB first.
//
// Ports
//   i_clk       clock
//   i_rst       synchronous, active-low reset
//   i_start     one-cycle dump request (accepted in IDLE only)
//   o_rf_addr   register-file read address
//   i_rf_data   combinational read data for o_rf_addr
//   o_tx_data   byte presented to the UART transmitter
//   o_tx_start  one-cycle pulse: UART latches o_tx_data
//   i_tx_done   one-cycle pulse: UART finished the current byte
//   o_busy      high from the first LOAD cycle through DONE
//   o_done      one-cycle pulse once the last byte is acknowledged
module reg_dump_unit #(
  parameter int LEN     = 32,
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_rf_addr,
  input  logic [LEN-1:0]     i_rf_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BYTES_PER_REG = LEN / NB_BYTE;
  localparam int NB_CNT        = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;

  localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(BYTES_PER_REG - 1);
  localparam logic [NB_ADDR-1:0] LAST_REG  = NB_ADDR'(NB_REG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state;
  logic [NB_ADDR-1:0] reg_idx;
  logic [NB_CNT-1:0]  byte_cnt;
  logic [LEN-1:0]     shift;
  logic               tx_start;
  logic               busy;
  logic               done;

  // The read address is the register index itself, so the register file
  // already presents the right word during the LOAD cycle.
  assign o_rf_addr  = reg_idx;
  assign o_tx_data  = shift[LEN-1 -: NB_BYTE];
  assign o_tx_start = tx_start;
  assign o_busy     = busy;
  assign o_done     = done;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= S_IDLE;
      reg_idx  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Pulse outputs default low; the states that own them set them for
      // exactly the cycle of the state they are entering.
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            reg_idx  <= '0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Snapshot taken here; later writes to this register are not seen.
          shift    <= i_rf_data;
          byte_cnt <= '0;
          tx_start <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          // i_tx_done is deliberately not looked at here.
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_tx_done) begin
            shift <= shift << NB_BYTE;
            if (byte_cnt == LAST_BYTE) begin
              state <= S_NEXT;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              tx_start <= 1'b1;
              state    <= S_SEND;
            end
          end
        end
        S_NEXT: begin
          if (reg_idx == LAST_REG) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            reg_idx <= reg_idx + 1'b1;
            state   <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit
//   Self-checking bench for reg_dump_unit. A behavioural register file and
//   UART (configurable per-byte stall, optional stray tx_done during SEND)
//   surround the DUT; expected byte streams are built from register
//   snapshots with plain arithmetic.
module tb_reg_dump_unit;

  localparam int LEN     = 32;
  localparam int NB_REG  = 32;
  localparam int NB_ADDR = 5;
  localparam int NB_BYTE = 8;
  localparam int NBYTES  = NB_REG * LEN / NB_BYTE;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [NB_ADDR-1:0] rf_addr;
  logic [LEN-1:0]     rf_data;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start;
  logic               tx_done = 1'b0;
  logic               busy;
  logic               done;

  reg_dump_unit #(
    .LEN    (LEN),
    .NB_REG (NB_REG),
    .NB_ADDR(NB_ADDR),
    .NB_BYTE(NB_BYTE)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .o_rf_addr (rf_addr),
    .i_rf_data (rf_data),
    .o_tx_data (tx_data),
    .o_tx_start(tx_start),
    .i_tx_done (tx_done),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file with combinational read.
  logic [31:0] rf   [NB_REG];
  logic [31:0] snap [NB_REG];
  assign rf_data = rf[rf_addr];

  int errors = 0;
  int checks = 0;

  logic [7:0] got   [$];
  logic [7:0] exp_q [$];
  logic [7:0] first [$];

  // UART model state
  int         stall = 0;     // stall cycles per byte; negative = random 0..3
  bit         spur_en = 1'b0;
  bit         pending = 1'b0;
  int         cnt = 0;
  logic [7:0] held = '0;
  int         hold_bad = 0;
  int         proto_err = 0;

  int unsigned start_cyc = 0;

  // UART: latch the byte on tx_start, wait the stall, pulse tx_done once.
  initial begin
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (pending) begin
        if (tx_data !== held) hold_bad++;
        if (tx_start === 1'b1) proto_err++;
        if (cnt == 0) begin
          tx_done = 1'b1;
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end else if (tx_start === 1'b1) begin
        got.push_back(tx_data);
        held    = tx_data;
        pending = 1'b1;
        cnt     = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        if (spur_en) tx_done = 1'b1;
      end
    end
  end

  function automatic void build_exp();
    exp_q.delete();
    for (int n = 0; n < NB_REG; n++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'((snap[n] >> (24 - 8 * b)) & 32'hFF));
  endfunction

  task automatic randomize_rf();
    for (int n = 0; n < NB_REG; n++) rf[n] = $urandom;
  endtask

  task automatic start_dump();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for o_done; optionally re-pulses start at rel 3/150 and writes
  // R5/R20 at rel write_at. drel = cycle of o_done relative to start.
  task automatic wait_done(input bit repulse, input int write_at,
                           output bit ok, output int drel);
    int rel;
    ok   = 1'b0;
    drel = -1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      rel   = int'(cyc - start_cyc);
      start = repulse && (rel == 3 || rel == 150);
      if (rel == write_at) begin
        rf[5]  = 32'hCAFEBABE;
        rf[20] = 32'hCAFEBABE;
      end
      if (done === 1'b1) begin
        ok   = 1'b1;
        drel = rel;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {tx_start, busy, done});
    end
    checks++;
    if (rf_addr !== '0) begin
      errors++; $display("FAIL reset_addr: got %0h want 0", rf_addr);
    end
    checks++;
    if (tx_data !== '0) begin
      errors++; $display("FAIL reset_txdata: got %0h want 0", tx_data);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_start, busy, done} !== 3'b000) begin
      errors++; $display("FAIL idle_flags: got %b want 000", {tx_start, busy, done});
    end
  endtask

  task automatic test_basic();
    bit ok; int drel; int nbad;
    for (int n = 0; n < NB_REG; n++) rf[n] = 32'h11223300 + n;
    snap = rf; build_exp();
    got.delete(); stall = 0; spur_en = 1'b0;
    @(negedge clk);
    start = 1'b1; start_cyc = cyc;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_c0: got %b want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, tx_start, rf_addr} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL basic_load_c1: got busy=%b start=%b addr=%0d want 1 0 0",
                         busy, tx_start, rf_addr);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h11) begin
      errors++; $display("FAIL basic_send_c2: got start=%b data=%0h want 1 11", tx_start, tx_data);
    end
    wait_done(1'b0, -1, ok, drel);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_timeout: got no done want done");
    end
    checks++;
    if (drel !== 321) begin
      errors++; $display("FAIL basic_done_cycle: got %0d want 321", drel);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_at_done: got %b want 1", busy);
    end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    checks++;
    if (got.size() !== NBYTES || nbad != 0) begin
      errors++; $display("FAIL basic_stream: got %0d bytes %0d bad want %0d bytes 0 bad",
                         got.size(), nbad, NBYTES);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_stall();
    bit ok; int drel; int nbad;
    logic [31:0] r1w;
    randomize_rf(); rf[1] = 32'hDEADBEEF;
    snap = rf; build_exp();
    got.delete(); stall = 5; spur_en = 1'b0; hold_bad = 0; proto_err = 0;
    start_dump();
    wait_done(1'b0, -1, ok, drel);
    checks++;
    if (!ok || drel !== 961) begin
      errors++; $display("FAIL stall_done_cycle: got ok=%b rel=%0d want 1 961", ok, drel);
    end
    checks++;
    if (hold_bad !== 0 || proto_err !== 0) begin
      errors++; $display("FAIL stall_hold: got hold_bad=%0d proto=%0d want 0 0", hold_bad, proto_err);
    end
    r1w = '0;
    if (got.size() >= 8) r1w = {got[4], got[5], got[6], got[7]};
    checks++;
    if (r1w !== 32'hDEADBEEF) begin
      errors++; $display("FAIL stall_r1: got %08h want deadbeef", r1w);
    end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    checks++;
    if (got.size() !== NBYTES || nbad != 0) begin
      errors++; $display("FAIL stall_stream: got %0d bytes %0d bad want %0d bytes 0 bad",
                         got.size(), nbad, NBYTES);
    end
  endtask

  task automatic test_restart_spurious();
    bit ok; int drel; int nbad; int extra;
    randomize_rf();
    snap = rf; build_exp();
    got.delete(); stall = 3; spur_en = 1'b1; hold_bad = 0; proto_err = 0;
    start_dump();
    wait_done(1'b1, -1, ok, drel);
    checks++;
    if (!ok || drel !== 705) begin
      errors++; $display("FAIL spur_done_cycle: got ok=%b rel=%0d want 1 705", ok, drel);
    end
    checks++;
    if (hold_bad !== 0 || proto_err !== 0) begin
      errors++; $display("FAIL spur_hold: got hold_bad=%0d proto=%0d want 0 0", hold_bad, proto_err);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL spur_single_done: got %0d extra active cycles want 0", extra);
    end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    checks++;
    if (got.size() !== NBYTES || nbad != 0) begin
      errors++; $display("FAIL spur_stream: got %0d bytes %0d bad want %0d bytes 0 bad",
                         got.size(), nbad, NBYTES);
    end
    spur_en = 1'b0;
  endtask

  task automatic test_write_during();
    bit ok; int drel; int nbad;
    logic [31:0] r5w, r20w;
    randomize_rf();
    snap = rf;
    // Register n is read at cycle 1+10n with a zero-wait UART; the write
    // lands at cycle 100, so only registers read later see it.
    for (int n = 0; n < NB_REG; n++)
      if ((n == 5 || n == 20) && (1 + 10 * n > 100)) snap[n] = 32'hCAFEBABE;
    build_exp();
    got.delete(); stall = 0;
    start_dump();
    wait_done(1'b0, 100, ok, drel);
    checks++;
    if (!ok || drel !== 321) begin
      errors++; $display("FAIL write_done_cycle: got ok=%b rel=%0d want 1 321", ok, drel);
    end
    r5w = '0; r20w = '0;
    if (got.size() == NBYTES) begin
      r5w  = {got[20], got[21], got[22], got[23]};
      r20w = {got[80], got[81], got[82], got[83]};
    end
    checks++;
    if (r5w !== snap[5]) begin
      errors++; $display("FAIL write_r5_old: got %08h want %08h", r5w, snap[5]);
    end
    checks++;
    if (r20w !== 32'hCAFEBABE) begin
      errors++; $display("FAIL write_r20_new: got %08h want cafebabe", r20w);
    end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    checks++;
    if (got.size() !== NBYTES || nbad != 0) begin
      errors++; $display("FAIL write_stream: got %0d bytes %0d bad want %0d bytes 0 bad",
                         got.size(), nbad, NBYTES);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int drel; int nbad; int extra; bit hit;
    randomize_rf();
    got.delete(); stall = 0;
    start_dump();
    hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (int'(cyc - start_cyc) == 77) begin
        hit = 1'b1;
        break;
      end
    end
    // Cycle 77 is the WAIT of register 7, byte 2.
    checks++;
    if (!hit || busy !== 1'b1 || tx_data !== 8'((rf[7] >> 8) & 32'hFF)) begin
      errors++; $display("FAIL rstmid_pre: got busy=%b data=%0h want 1 %0h",
                         busy, tx_data, 8'((rf[7] >> 8) & 32'hFF));
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({tx_start, busy, done, rf_addr, tx_data} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got start=%b busy=%b done=%b addr=%0h data=%0h want all 0",
                         tx_start, busy, done, rf_addr, tx_data);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || tx_start === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", extra);
    end
    checks++;
    if (got.size() !== 31) begin
      errors++; $display("FAIL rstmid_partial: got %0d bytes want 31", got.size());
    end
    snap = rf; build_exp(); got.delete();
    start_dump();
    wait_done(1'b0, -1, ok, drel);
    checks++;
    if (!ok || drel !== 321) begin
      errors++; $display("FAIL rstmid_redo_cycle: got ok=%b rel=%0d want 1 321", ok, drel);
    end
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    checks++;
    if (got.size() !== NBYTES || nbad != 0) begin
      errors++; $display("FAIL rstmid_stream: got %0d bytes %0d bad want %0d bytes 0 bad",
                         got.size(), nbad, NBYTES);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2; int d1, d2; int nbad;
    randomize_rf();
    snap = rf; build_exp();
    got.delete(); stall = -1;
    start_dump();
    wait_done(1'b0, -1, ok1, d1);
    first = got;
    got.delete();
    // start_dump raises i_start on the negedge right after o_done.
    start_dump();
    wait_done(1'b0, -1, ok2, d2);
    checks++;
    if (!ok1 || !ok2) begin
      errors++; $display("FAIL b2b_done: got ok1=%b ok2=%b want 1 1", ok1, ok2);
    end
    nbad = 0;
    foreach (exp_q[i]) if (i >= first.size() || first[i] !== exp_q[i]) nbad++;
    checks++;
    if (first.size() !== NBYTES || nbad != 0) begin
      errors++; $display("FAIL b2b_first: got %0d bytes %0d bad want %0d bytes 0 bad",
                         first.size(), nbad, NBYTES);
    end
    nbad = 0;
    foreach (first[i]) if (i >= got.size() || got[i] !== first[i]) nbad++;
    checks++;
    if (got.size() !== NBYTES || nbad != 0) begin
      errors++; $display("FAIL b2b_second: got %0d bytes %0d differ want %0d bytes 0 differ",
                         got.size(), nbad, NBYTES);
    end
    stall = 0;
  endtask

  initial begin
    for (int n = 0; n < NB_REG; n++) rf[n] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_restart_spurious();
    test_write_during();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Debug-side reader for the MIPS register file: on a start pulse it walks every architectural register through the file's combinational read port and streams each register as LEN/8 bytes to the UART transmitter, MSB first. It sits between the debug unit's command decoder and the UART TX, consuming the asynchronous read-data port while the pipeline is halted. It is the read-out counterpart of the register file's writeback path.

## Interface
Parameters:
- LEN, 32, register width in bits (multiple of 8)
- NB_REG, 32, number of registers dumped
- NB_ADDR, 5, register address width
- NB_BYTE, 8, UART byte width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_start  in  1  one-cycle request to begin a dump
- o_rf_addr  out  NB_ADDR  register-file read address
- i_rf_data  in  LEN  combinational read data for o_rf_addr
- o_tx_data  out  NB_BYTE  byte presented to UART TX
- o_tx_start  out  1  one-cycle pulse: UART latches o_tx_data
- i_tx_done  in  1  one-cycle pulse: UART finished current byte
- o_busy  out  1  high from first LOAD cycle until DONE inclusive
- o_done  out  1  one-cycle pulse when the last byte is acknowledged

## Operation
- States: IDLE, LOAD, SEND, WAIT, NEXT, DONE.
- IDLE: o_busy=0. i_start=1 -> LOAD, reg_idx=0, byte_cnt=0.
- LOAD: o_rf_addr=reg_idx; shift register <= i_rf_data; byte_cnt<=0 -> SEND.
- SEND: o_tx_start=1 for exactly this cycle -> WAIT.
- WAIT: hold until i_tx_done=1; then shift register <<= NB_BYTE. If byte_cnt==LEN/NB_BYTE-1 -> NEXT, else byte_cnt++ -> SEND.
- NEXT: if reg_idx==NB_REG-1 -> DONE, else reg_idx++ -> LOAD.
- DONE: o_done=1 for one cycle -> IDLE.
- o_tx_data = shift[LEN-1 -: NB_BYTE]. It is stable from SEND until the edge that consumes i_tx_done.
- Byte order: bits [LEN-1:LEN-8] are sent first, [7:0] last.
- Each register is snapshotted at its LOAD cycle. A register-file write occurring later in the dump is not reflected for that register; the dump is not atomic across registers.
- i_start is ignored while busy (LOAD..DONE). It is re-accepted in IDLE only.
- i_tx_done outside WAIT, including during the SEND cycle, is ignored and not remembered.
- reg_idx compare uses NB_REG-1. No wrap-around: the counter never exceeds NB_REG-1.

## Timing
- Reset (i_rst=0 at a rising edge): state=IDLE, o_rf_addr=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0, counters=0. This applies mid-dump as well; the byte in flight is abandoned and no o_done is issued.
- Start latency: i_start sampled at edge 0 -> LOAD in cycle 1 -> first o_tx_start in cycle 2.
- Per byte: minimum 2 cycles (SEND + one WAIT cycle with i_tx_done).
- Per register with zero-wait UART: 1 (LOAD) + 2·LEN/8 + 1 (NEXT) = 10 cycles at defaults.
- Full dump at defaults with zero-wait UART: o_done is high in cycle 321 (cycle 1 = first LOAD). Total transfer is NB_REG·LEN/8 = 128 o_tx_start pulses.
- Consecutive o_tx_start pulses are at least 2 cycles apart within a register and at least 4 cycles apart across registers.

## Test plan
- Register file preloaded with R[n]=0x11223300+n. Pulse start, instant tx_done -> 128 bytes in the order 11,22,33,00,11,22,33,01,…,11,22,33,1F. o_done is high in cycle 321 and o_busy drops the following cycle.
- UART stalls 5 cycles per byte with R1=0xDEADBEEF -> o_tx_data holds DE for all stall cycles, then AD, BE, EF. Exactly one o_tx_start per byte.
- i_start re-pulsed at cycles 3 and 150, plus spurious i_tx_done during SEND cycles -> the dump is unaffected: 128 bytes and a single o_done.
- R5 written to 0xCAFEBABE after reg_idx passes 5 -> the dump shows the old R5. A write to R20 before its LOAD -> the dump shows 0xCAFEBABE.
- i_rst=0 during the WAIT of register 7, byte 2 -> the next cycle shows all outputs 0 and IDLE. No o_done. A new start restarts from R0 byte 0.
- Back-to-back dumps: i_start in the cycle after o_done -> the second dump is identical to the first.
